// File: rtl/march_sequencer.sv
// march_sequencer: steps a BIST datapath through a stored march program.
// It records the first mismatch or a RUN timeout and reports pass/fail.
module march_sequencer #(
  parameter int sw    = 16,
  parameter int aw    = 8,
  parameter int depth = 8,
  parameter int pw    = 3,
  parameter int tmo   = 1023
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          prog_we_in,
  input  logic [pw-1:0] prog_addr_in,
  input  logic [sw-1:0] prog_data_in,
  input  logic [pw:0]   num_elem_in,
  input  logic          start_in,
  input  logic          elem_done_in,
  input  logic          cmp_valid_in,
  input  logic          passfail_in,
  input  logic [aw-1:0] tas_in,
  output logic [sw-1:0] scan_out,
  output logic          ts_out,
  output logic          busy_out,
  output logic          done_out,
  output logic          fail_out,
  output logic          timeout_out,
  output logic [pw-1:0] fail_elem_out,
  output logic [aw-1:0] fail_addr_out
);
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_RUN, S_NEXT, S_DONE} state_t;
  state_t r_state, w_next;
  logic [sw-1:0] r_prog [depth];
  logic [sw-1:0] r_scan;
  logic [pw:0]   r_n, w_n;
  logic [pw-1:0] r_idx, r_fail_elem;
  logic [aw-1:0] r_fail_addr;
  logic [15:0]   r_cnt;
  logic          r_fail, r_tmo;
  logic          w_idle, w_go, w_mis, w_to, w_last;
  assign w_idle = (r_state == S_IDLE) || (r_state == S_DONE);
  assign w_go   = w_idle && start_in;
  assign w_mis  = (r_state == S_RUN) && cmp_valid_in && passfail_in && !r_fail;
  // the cycle whose counter reads tmo-1 is the tmo-th RUN cycle
  assign w_to   = (r_state == S_RUN) && !elem_done_in && (r_cnt == 16'(tmo - 1));
  assign w_last = {1'b0, r_idx} == (r_n - (pw+1)'(1));
  assign w_n    = (num_elem_in == '0) ? (pw+1)'(1) :
                  (num_elem_in > (pw+1)'(depth)) ? (pw+1)'(depth) : num_elem_in;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: w_next = start_in ? S_LOAD : r_state;
      S_LOAD:         w_next = S_START;
      S_START:        w_next = S_RUN;
      S_RUN:          w_next = elem_done_in ? S_NEXT : w_to ? S_DONE : S_RUN;
      S_NEXT:         w_next = w_last ? S_DONE : S_LOAD;
      default:        w_next = S_IDLE;
    endcase
  end
  always_comb begin
    ts_out   = r_state == S_START;
    busy_out = (r_state == S_LOAD) || (r_state == S_START) || (r_state == S_RUN) || (r_state == S_NEXT);
    done_out = r_state == S_DONE;
  end
  always_ff @(posedge clk)
    if (prog_we_in && w_idle) r_prog[prog_addr_in] <= prog_data_in;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_scan      <= '0;
      r_n         <= '0;
      r_idx       <= '0;
      r_cnt       <= '0;
      r_fail      <= 1'b0;
      r_tmo       <= 1'b0;
      r_fail_elem <= '0;
      r_fail_addr <= '0;
    end else begin
      if (w_go) begin
        r_n         <= w_n;
        r_idx       <= '0;
        r_fail      <= 1'b0;
        r_tmo       <= 1'b0;
        r_fail_elem <= '0;
        r_fail_addr <= '0;
      end
      if (r_state == S_LOAD) r_scan <= r_prog[r_idx];
      r_cnt <= (r_state == S_RUN) ? r_cnt + 16'd1 : '0;
      if (w_mis) begin
        r_fail      <= 1'b1;
        r_fail_elem <= r_idx;
        r_fail_addr <= tas_in;
      end
      if (w_to) begin
        r_tmo  <= 1'b1;
        r_fail <= 1'b1;
        if (!r_fail) r_fail_elem <= r_idx;
      end
      if (r_state == S_NEXT && !w_last) r_idx <= r_idx + pw'(1);
    end
  end
  assign scan_out      = r_scan;
  assign fail_out      = r_fail;
  assign timeout_out   = r_tmo;
  assign fail_elem_out = r_fail_elem;
  assign fail_addr_out = r_fail_addr;
endmodule

// File: doc/march_sequencer.md
Name: march_sequencer

Overview:
- Sequences the memory BIST datapath through a stored march algorithm.
- Holds up to `depth` march-element scan words and presents them one at a time on `scan_out`, which drives the datapath scan input.
- Pulses `ts_out` to launch each element, then waits for the element-complete indication.
- Captures the first mismatch (element index and address) and reports overall pass/fail.
- Sits between the test-access/host logic and the BIST top level.

Parameters:
- sw, 16, scan word width; matches the datapath scan input.
- aw, 8, address width; matches the datapath TAS bus.
- depth, 8, number of program entries (power of two).
- pw, 3, program index width; equals log2(depth).
- tmo, 1023, RUN-state timeout in cycles; must be < 2^16.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- prog_we_in  in  1  program write strobe; honoured only in IDLE or DONE.
- prog_addr_in  in  pw  program entry index.
- prog_data_in  in  sw  scan word to store.
- num_elem_in  in  pw+1  number of elements to run (1..depth); sampled on start.
- start_in  in  1  run request; level, acted on in IDLE or DONE.
- elem_done_in  in  1  element complete; address reached the final boundary for this element's direction.
- cmp_valid_in  in  1  compare result valid this cycle.
- passfail_in  in  1  comparator result; 1 = mismatch.
- tas_in  in  aw  current datapath address.
- scan_out  out  sw  scan word to datapath.
- ts_out  out  1  test-start pulse.
- busy_out  out  1  high in LOAD, START, RUN, NEXT.
- done_out  out  1  high in DONE.
- fail_out  out  1  sticky mismatch-or-timeout flag.
- timeout_out  out  1  sticky timeout flag.
- fail_elem_out  out  pw  element index of first failure.
- fail_addr_out  out  aw  address of first mismatch.

Behaviour:
- Reset: state IDLE; all outputs 0; program storage is not reset. Reset mid-run aborts to IDLE within the same cycle (asynchronous).
- Program storage: a write with prog_we_in=1 in IDLE/DONE stores prog_data_in at prog_addr_in on the next edge. Writes in any other state are ignored.
- IDLE: start_in=1 → latch n = num_elem_in (0 treated as 1; >depth clamped to depth); idx=0; clear fail_out, timeout_out, fail_elem_out, fail_addr_out; go to LOAD.
- LOAD (1 cycle): scan_out = prog[idx], registered. scan_out then holds this value through START, RUN and NEXT.
- START (1 cycle): ts_out=1. This is the only state where ts_out is high.
- RUN: a cycle counter starts at 0 and increments each cycle.
  - cmp_valid_in=1 and passfail_in=1 while fail_out=0 → set fail_out; capture fail_elem_out=idx and fail_addr_out=tas_in. Later mismatches do not overwrite.
  - elem_done_in=1 → NEXT. A compare in the same cycle as elem_done_in is still evaluated.
  - Counter reaching tmo with no elem_done_in → set timeout_out and fail_out (fail_elem_out=idx if not already failed, fail_addr_out unchanged if already failed), go to DONE.
- NEXT (1 cycle): if idx == n-1 → DONE, else idx+1 → LOAD. Fail does not abort the run; all elements execute.
- DONE: done_out=1; results held. start_in=1 restarts as from IDLE (results cleared). start_in held high in DONE restarts repeatedly.
- elem_done_in, cmp_valid_in and passfail_in are ignored outside RUN.
- Latency, start to first ts_out: 2 cycles (IDLE→LOAD→START).
- Per-element overhead: LOAD + START + NEXT = 3 cycles plus RUN length.

Test Plan:
- Program 3 words 0x1111/0x2222/0x3333, num_elem=3, start; elem_done_in after 4 RUN cycles each, no mismatches → ts_out pulses 3 times, scan_out shows each word in order, done_out=1, fail_out=0, busy high throughout.
- Same run; passfail_in=1 with cmp_valid_in on element 1 at tas_in=0x2A, then again at 0x30 → fail_out=1, fail_elem_out=1, fail_addr_out=0x2A, all 3 elements still run.
- tmo=20, elem_done_in never asserted → timeout_out=1, fail_out=1 at cycle 20 of RUN, DONE, ts_out pulsed once.
- Assert rst during RUN of element 2 → outputs 0 immediately; new start without reprogramming replays the stored words.
- num_elem_in=0 → exactly 1 element runs; num_elem_in=9 with depth 8 → 8 elements run.
- prog_we_in during RUN → storage unchanged (verify on next run); mismatch coincident with elem_done_in → captured.
